// File: rtl/axi_axis_fifo_writer.sv
// AXI4-Lite slave that turns each register write into one AXI4-Stream beat through a FIFO.
// Address bit 2 of the write selects tlast; reads report FIFO fill (bit2=0) or free (bit2=1) count.
module axi_axis_fifo_writer #(
  parameter int AXI_DATA_WIDTH  = 32,
  parameter int AXI_ADDR_WIDTH  = 16,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic [AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic                      s_axi_awvalid,
  output logic                      s_axi_awready,
  input  logic [AXI_DATA_WIDTH-1:0] s_axi_wdata,
  input  logic                      s_axi_wvalid,
  output logic                      s_axi_wready,
  output logic [1:0]                s_axi_bresp,
  output logic                      s_axi_bvalid,
  input  logic                      s_axi_bready,
  input  logic [AXI_ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic                      s_axi_arvalid,
  output logic                      s_axi_arready,
  output logic [AXI_DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]                s_axi_rresp,
  output logic                      s_axi_rvalid,
  input  logic                      s_axi_rready,
  output logic [AXI_DATA_WIDTH-1:0] m_axis_tdata,
  output logic                      m_axis_tlast,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready
);

  localparam int unsigned DEPTH = 2 ** FIFO_DEPTH_LOG2;
  localparam int PAD = AXI_DATA_WIDTH - FIFO_DEPTH_LOG2 - 1;
  localparam logic [FIFO_DEPTH_LOG2:0]   DEPTH_CNT = DEPTH[FIFO_DEPTH_LOG2:0];
  localparam logic [FIFO_DEPTH_LOG2:0]   CNT_ONE   = (FIFO_DEPTH_LOG2 + 1)'(1'b1);
  localparam logic [FIFO_DEPTH_LOG2:0]   CNT_ZERO  = {(FIFO_DEPTH_LOG2 + 1){1'b0}};
  localparam logic [FIFO_DEPTH_LOG2-1:0] PTR_ONE   = FIFO_DEPTH_LOG2'(1'b1);
  localparam logic [FIFO_DEPTH_LOG2-1:0] PTR_ZERO  = {FIFO_DEPTH_LOG2{1'b0}};

  logic                        aw_full;
  logic                        aw_last;
  logic                        w_full;
  logic [AXI_DATA_WIDTH-1:0]   w_data;
  logic [FIFO_DEPTH_LOG2:0]    count;
  logic [FIFO_DEPTH_LOG2-1:0]  wr_ptr;
  logic [FIFO_DEPTH_LOG2-1:0]  rd_ptr;
  logic [AXI_DATA_WIDTH:0]     mem [DEPTH];
  logic [AXI_DATA_WIDTH:0]     head;
  logic [AXI_DATA_WIDTH-1:0]   read_value;
  logic                        push;
  logic                        pop;
  logic                        unused_addr;

  assign s_axi_awready = ~aw_full;
  assign s_axi_wready  = ~w_full;
  assign s_axi_arready = ~s_axi_rvalid;
  assign s_axi_bresp   = 2'b00;
  assign s_axi_rresp   = 2'b00;
  assign head          = mem[rd_ptr];
  assign m_axis_tdata  = head[AXI_DATA_WIDTH-1:0];
  assign m_axis_tlast  = head[AXI_DATA_WIDTH];
  assign m_axis_tvalid = (count != CNT_ZERO);
  assign unused_addr   = ^{s_axi_awaddr, s_axi_araddr};

  // Push needs both halves of the write, FIFO room, and a free B slot; a full FIFO never accepts even when popping.
  always_comb begin
    push = 1'b0;
    pop  = 1'b0;
    if (aw_full && w_full && (count != DEPTH_CNT) && (!s_axi_bvalid || s_axi_bready)) begin
      push = 1'b1;
    end else begin
      push = 1'b0;
    end
    if (m_axis_tvalid && m_axis_tready) begin
      pop = 1'b1;
    end else begin
      pop = 1'b0;
    end
  end

  // Register read value: fill count or free space, zero-extended.
  always_comb begin
    read_value = {AXI_DATA_WIDTH{1'b0}};
    if (s_axi_araddr[2]) begin
      read_value = {{PAD{1'b0}}, DEPTH_CNT - count};
    end else begin
      read_value = {{PAD{1'b0}}, count};
    end
  end

  // AW and W holding registers, emptied together on push.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      aw_full <= 1'b0;
      aw_last <= 1'b0;
      w_full  <= 1'b0;
      w_data  <= {AXI_DATA_WIDTH{1'b0}};
    end else begin
      if (push) begin
        aw_full <= 1'b0;
        w_full  <= 1'b0;
      end else begin
        if (s_axi_awvalid && !aw_full) begin
          aw_full <= 1'b1;
          aw_last <= s_axi_awaddr[2];
        end
        if (s_axi_wvalid && !w_full) begin
          w_full <= 1'b1;
          w_data <= s_axi_wdata;
        end
      end
    end
  end

  // Write response: set on push, cleared on handshake.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      s_axi_bvalid <= 1'b0;
    end else if (push) begin
      s_axi_bvalid <= 1'b1;
    end else if (s_axi_bready) begin
      s_axi_bvalid <= 1'b0;
    end
  end

  // FIFO storage; contents need no reset since tvalid gates them.
  always_ff @(posedge aclk) begin
    if (push) begin
      mem[wr_ptr] <= {aw_last, w_data};
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr <= PTR_ZERO;
      rd_ptr <= PTR_ZERO;
      count  <= CNT_ZERO;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Read channel: value captured at the AR handshake and held until taken.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      s_axi_rvalid <= 1'b0;
      s_axi_rdata  <= {AXI_DATA_WIDTH{1'b0}};
    end else if (s_axi_arvalid && !s_axi_rvalid) begin
      s_axi_rvalid <= 1'b1;
      s_axi_rdata  <= read_value;
    end else if (s_axi_rready) begin
      s_axi_rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi_axis_fifo_writer.sv
// Bench for axi_axis_fifo_writer: directed scenarios plus randomized traffic,
// checked against a queue model of the beats written and the responses owed.
module tb_axi_axis_fifo_writer;

  localparam int DEPTH = 16;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [15:0] s_axi_awaddr;
  logic        s_axi_awvalid;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata;
  logic        s_axi_wvalid;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready;
  logic [15:0] s_axi_araddr;
  logic        s_axi_arvalid;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid;
  logic        s_axi_rready;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tlast;
  logic        m_axis_tvalid;
  logic        m_axis_tready;

  int          vectors = 0;
  int          miscompares = 0;
  int          b_count = 0;
  int          writes_issued = 0;
  bit          rand_mode = 1'b0;
  logic [32:0] exp_q [$];

  always #5 aclk = ~aclk;

  axi_axis_fifo_writer #(
    .AXI_DATA_WIDTH(32),
    .AXI_ADDR_WIDTH(16),
    .FIFO_DEPTH_LOG2(4)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid),
    .s_axi_rready(s_axi_rready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Model fill level: every written beat not yet streamed, capped at the FIFO depth.
  function automatic int exp_fill();
    return (exp_q.size() > DEPTH) ? DEPTH : exp_q.size();
  endfunction

  // Stream and B monitor; decisions made mid-cycle predict the next rising edge.
  always @(negedge aclk) begin
    logic [32:0] beat;
    if (aresetn) begin
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          check_eq("stream_extra_beat", 64'(exp_q.size()), 64'd1);
        end else begin
          beat = exp_q.pop_front();
          check_eq("tdata", 64'(m_axis_tdata), 64'(beat[31:0]));
          check_eq("tlast", 64'(m_axis_tlast), 64'(beat[32]));
        end
      end
      if (s_axi_bvalid && s_axi_bready) begin
        b_count++;
        check_eq("bresp", 64'(s_axi_bresp), 64'd0);
      end
    end
  end

  always @(posedge aclk) begin
    if (rand_mode) begin
      #1;
      m_axis_tready = 1'($urandom_range(0, 1));
      s_axi_bready  = 1'($urandom_range(0, 1));
    end
  end

  task automatic wait_hs(input int ch);
    int n = 0;
    bit rdy = 1'b0;
    forever begin
      @(negedge aclk);
      rdy = (ch == 0) ? s_axi_awready : ((ch == 1) ? s_axi_wready : s_axi_arready);
      if (rdy || n > 300) break;
      n++;
    end
    if (!rdy) check_eq("handshake_timeout", 64'(rdy), 64'd1);
    @(posedge aclk);
    #1;
  endtask

  task automatic axi_write(input logic last, input logic [31:0] data, input int aw_dly, input int w_dly);
    exp_q.push_back({last, data});
    writes_issued++;
    fork
      begin
        repeat (aw_dly) @(posedge aclk);
        #1;
        s_axi_awaddr  = last ? 16'h0004 : 16'h0000;
        s_axi_awvalid = 1'b1;
        wait_hs(0);
        s_axi_awvalid = 1'b0;
      end
      begin
        repeat (w_dly) @(posedge aclk);
        #1;
        s_axi_wdata  = data;
        s_axi_wvalid = 1'b1;
        wait_hs(1);
        s_axi_wvalid = 1'b0;
      end
    join
  endtask

  task automatic axi_read(input logic sel, output logic [31:0] data);
    int n = 0;
    s_axi_araddr  = sel ? 16'h0004 : 16'h0000;
    s_axi_arvalid = 1'b1;
    wait_hs(2);
    s_axi_arvalid = 1'b0;
    while (n < 100) begin
      @(negedge aclk);
      if (s_axi_rvalid) break;
      n++;
    end
    check_eq("rvalid_seen", 64'(s_axi_rvalid), 64'd1);
    check_eq("rresp", 64'(s_axi_rresp), 64'd0);
    data = s_axi_rdata;
    @(posedge aclk);
    #1;
  endtask

  task automatic wait_b(input int nb);
    int n = 0;
    while ((b_count < nb || (m_axis_tready && exp_q.size() != 0)) && n < 1000) begin
      @(negedge aclk);
      n++;
    end
    check_eq("b_count", 64'(b_count), 64'(nb));
    @(posedge aclk);
    #1;
  endtask

  initial begin
    logic [31:0] rd;
    aresetn = 1'b0;
    s_axi_awaddr = 16'h0000; s_axi_awvalid = 1'b0;
    s_axi_wdata = 32'h0; s_axi_wvalid = 1'b0;
    s_axi_bready = 1'b1;
    s_axi_araddr = 16'h0000; s_axi_arvalid = 1'b0;
    s_axi_rready = 1'b1;
    m_axis_tready = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    check_eq("rst_awready", 64'(s_axi_awready), 64'd1);
    check_eq("rst_wready", 64'(s_axi_wready), 64'd1);
    check_eq("rst_arready", 64'(s_axi_arready), 64'd1);
    check_eq("rst_bvalid", 64'(s_axi_bvalid), 64'd0);
    check_eq("rst_rvalid", 64'(s_axi_rvalid), 64'd0);
    check_eq("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    check_eq("rst_rdata", 64'(s_axi_rdata), 64'd0);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;

    // Single write, AW and W together: beat and response one cycle after the push.
    m_axis_tready = 1'b1;
    axi_write(1'b0, 32'hDEADBEEF, 0, 0);
    check_eq("t1_tvalid_before_push", 64'(m_axis_tvalid), 64'd0);
    @(posedge aclk);
    #1;
    check_eq("t1_tvalid", 64'(m_axis_tvalid), 64'd1);
    check_eq("t1_bvalid", 64'(s_axi_bvalid), 64'd1);
    check_eq("t1_tdata", 64'(m_axis_tdata), 64'hDEADBEEF);
    @(posedge aclk);
    #1;
    check_eq("t1_tvalid_pulse", 64'(m_axis_tvalid), 64'd0);
    wait_b(writes_issued);

    // W three cycles ahead of AW, tlast offset.
    fork
      axi_write(1'b1, 32'h5, 3, 0);
      begin
        @(negedge aclk);
        @(negedge aclk);
        check_eq("t2_wready_held", 64'(s_axi_wready), 64'd0);
        check_eq("t2_awready", 64'(s_axi_awready), 64'd1);
        check_eq("t2_no_push", 64'(m_axis_tvalid), 64'd0);
      end
    join
    wait_b(writes_issued);

    // Fill the FIFO with the stream stalled; the 17th write waits in the holding registers.
    m_axis_tready = 1'b0;
    for (int i = 1; i <= 17; i++) axi_write(1'b0, 32'(i), 0, 0);
    wait_b(writes_issued - 1);
    check_eq("t3_awready_stall", 64'(s_axi_awready), 64'd0);
    check_eq("t3_wready_stall", 64'(s_axi_wready), 64'd0);
    axi_read(1'b0, rd);
    check_eq("t3_fill", 64'(rd), 64'(exp_fill()));
    axi_read(1'b1, rd);
    check_eq("t3_free", 64'(rd), 64'(DEPTH - exp_fill()));
    m_axis_tready = 1'b1;
    wait_b(writes_issued);
    check_eq("t3_drained", 64'(exp_q.size()), 64'd0);

    // Back-to-back writes with the stream always ready; pointers wrap several times.
    for (int i = 0; i < 40; i++) axi_write(1'($urandom_range(0, 1)), $urandom, 0, 0);
    wait_b(writes_issued);
    axi_read(1'b0, rd);
    check_eq("t4_fill", 64'(rd), 64'(exp_fill()));

    // bready held low: the second write parks in the holding registers.
    s_axi_bready = 1'b0;
    axi_write(1'b0, 32'hA5A50001, 0, 0);
    axi_write(1'b1, 32'hA5A50002, 0, 0);
    repeat (3) @(posedge aclk);
    #1;
    check_eq("t5_bvalid_held", 64'(s_axi_bvalid), 64'd1);
    check_eq("t5_awready_parked", 64'(s_axi_awready), 64'd0);
    check_eq("t5_b_pending", 64'(b_count), 64'(writes_issued - 2));
    s_axi_bready = 1'b1;
    wait_b(writes_issued);
    repeat (4) @(posedge aclk);
    #1;
    check_eq("t5_one_b_per_write", 64'(b_count), 64'(writes_issued));

    // Randomized traffic with random stream and response backpressure.
    rand_mode = 1'b1;
    for (int i = 0; i < 40; i++)
      axi_write(1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
    rand_mode = 1'b0;
    @(posedge aclk);
    #2;
    m_axis_tready = 1'b1;
    s_axi_bready = 1'b1;
    wait_b(writes_issued);
    check_eq("t6_drained", 64'(exp_q.size()), 64'd0);

    // Reset with five beats queued and one response outstanding.
    m_axis_tready = 1'b0;
    for (int i = 0; i < 4; i++) axi_write(1'b0, $urandom, 0, 0);
    wait_b(writes_issued);
    s_axi_bready = 1'b0;
    axi_write(1'b1, 32'h0BADF00D, 0, 0);
    repeat (3) @(posedge aclk);
    #1;
    check_eq("t7_bvalid_pre", 64'(s_axi_bvalid), 64'd1);
    axi_read(1'b0, rd);
    check_eq("t7_fill_pre", 64'(rd), 64'(exp_fill()));
    @(posedge aclk);
    #2;
    aresetn = 1'b0;
    #1;
    check_eq("t7_tvalid_async", 64'(m_axis_tvalid), 64'd0);
    check_eq("t7_bvalid_async", 64'(s_axi_bvalid), 64'd0);
    check_eq("t7_rvalid_async", 64'(s_axi_rvalid), 64'd0);
    check_eq("t7_awready_async", 64'(s_axi_awready), 64'd1);
    exp_q.delete();
    writes_issued = b_count;
    s_axi_bready = 1'b1;
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    axi_read(1'b0, rd);
    check_eq("t7_fill_post", 64'(rd), 64'(exp_fill()));
    repeat (3) @(posedge aclk);
    #1;
    check_eq("t7_no_stale_b", 64'(b_count), 64'(writes_issued));
    m_axis_tready = 1'b1;
    axi_write(1'b1, 32'h12345678, 0, 0);
    wait_b(writes_issued);
    check_eq("t7_post_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axi_axis_fifo_writer.md
Name: axi_axis_fifo_writer

Overview:
- AXI4-Lite slave that converts register writes into an AXI4-Stream with tready backpressure.
- Each write is buffered in an internal FIFO. The write address offset selects the tlast flag for that beat.
- Reads return FIFO fill and free counts.
- Sits between the PS general-purpose AXI port and stream consumers (DMA, DDS, config chains) that can stall.

Parameters:
- AXI_DATA_WIDTH, 32, width of s_axi_wdata/s_axi_rdata and m_axis_tdata.
- AXI_ADDR_WIDTH, 16, width of s_axi_awaddr/s_axi_araddr.
- FIFO_DEPTH_LOG2, 4, log2 of FIFO depth in entries (default 16); legal range 1..10.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  reset, asynchronous assert, active-low.
- s_axi_awaddr  in  AXI_ADDR_WIDTH  write address; only bit 2 is decoded.
- s_axi_awvalid  in  1  write address valid.
- s_axi_awready  out  1  write address ready.
- s_axi_wdata  in  AXI_DATA_WIDTH  write data.
- s_axi_wvalid  in  1  write data valid.
- s_axi_wready  out  1  write data ready.
- s_axi_bresp  out  2  write response, always 2'd0.
- s_axi_bvalid  out  1  write response valid.
- s_axi_bready  in  1  write response ready.
- s_axi_araddr  in  AXI_ADDR_WIDTH  read address; only bit 2 is decoded.
- s_axi_arvalid  in  1  read address valid.
- s_axi_arready  out  1  read address ready.
- s_axi_rdata  out  AXI_DATA_WIDTH  read data.
- s_axi_rresp  out  2  read response, always 2'd0.
- s_axi_rvalid  out  1  read data valid.
- s_axi_rready  in  1  read data ready.
- m_axis_tdata  out  AXI_DATA_WIDTH  stream data from the FIFO head.
- m_axis_tlast  out  1  stream last flag from the FIFO head.
- m_axis_tvalid  out  1  FIFO not empty.
- m_axis_tready  in  1  stream ready.

Behaviour:
- Reset (aresetn low, asynchronous):
  - FIFO pointers and count cleared; AW and W holding registers emptied.
  - awready=1, wready=1, bvalid=0, arready=1, rvalid=0, m_axis_tvalid=0, rdata=0.
  - Reset mid-transaction discards all buffered and pending beats; no bvalid is issued for them.
- AW and W are accepted independently, each into a one-entry holding register:
  - awready = AW register empty; wready = W register empty.
  - On AW handshake, store awaddr[2]. On W handshake, store wdata.
  - Either channel may arrive first or in the same cycle.
- Push condition, evaluated each cycle: AW register full AND W register full AND FIFO not full AND (bvalid=0 OR bready=1).
  - On push: write entry {tlast=aw_bit2, data=wdata} at the write pointer.
  - Empty both holding registers, so awready and wready return to 1 the next cycle.
  - Set bvalid=1 the next cycle.
- bvalid clears on the bvalid&bready handshake unless a new push occurs in the same cycle.
- FIFO full: no push. Holding registers stay full and awready/wready stay low, so the master stalls without loss. No SLVERR is ever returned.
- Stream output:
  - Registered-index read: tdata/tlast reflect the head entry; m_axis_tvalid = (count != 0).
  - A pop occurs on tvalid&tready; the head advances and the next entry appears in the next cycle.
- Latency: push in cycle t; tvalid=1 and bvalid=1 in cycle t+1 (FIFO previously empty).
- Count: width FIFO_DEPTH_LOG2+1.
  - +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
  - A push into a full FIFO is blocked even if a pop occurs in the same cycle (no same-cycle pass-through when full).
- Pointers: width FIFO_DEPTH_LOG2, wrap modulo depth.
- Read channel:
  - arready = ~rvalid. On AR handshake, rvalid=1 in the next cycle.
  - araddr[2]=0: rdata = fill count, zero-extended. araddr[2]=1: rdata = free count (depth - count), zero-extended.
  - The value is sampled at the AR handshake cycle and held until rvalid&rready.
- Write data is used whole; there is no strobe port.

Test Plan:
- Single write: wdata=0xDEADBEEF to offset 0x0 with AW/W simultaneous, tready=1 → tvalid pulse one cycle later, tdata=0xDEADBEEF, tlast=0, bvalid one cycle after push, bresp=0.
- W leads AW by 3 cycles; write to offset 0x4 with data 0x5 → wready low after W accepted; push only after AW; output tdata=0x5, tlast=1.
- tready=0, 17 writes with data 1..17 (depth 16) → 16 writes complete, 17th stalls with awready/wready low; read offset 0 returns 16, offset 4 returns 0; raise tready → stream 1..17 in order, 17th bresp follows.
- Continuous writes with tready=1 every cycle and bready=1 → count stays ≤1, no lost or duplicated beats; wrap past pointer 15→0 verified over 40 beats.
- bready held low after first write → second write is accepted into the holding registers but not pushed until bready=1; exactly one bvalid per write.
- Assert aresetn low mid-stream with 5 entries queued → same cycle (async) tvalid=0, bvalid=0, rvalid=0; after release, fill count reads 0.
